// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the six-way round-robin arbiter.
//   arb_state_e : FSM state encoding (IDLE, BUSY)
//   ARB_N       : number of requesters
//   PTR_W       : width of the priority pointer / winner index
package arb_pkg;

    localparam int ARB_N = 6;
    localparam int PTR_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick6.sv
// rr_pick6: combinational round-robin pick over six requesters.
// The search starts at ptr+1 (mod 6) and returns the first set request.
// This makes the requester at ptr rank lowest.
// Ports:
//   req     in  [5:0]  request vector
//   ptr     in  [2:0]  index of the last winner (0..5)
//   win     out [5:0]  one-hot winner, zero when no request is set
//   win_idx out [2:0]  index of the winner (0 when win is zero)
module rr_pick6
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [ARB_N-1:0] win,
    output logic [PTR_W-1:0] win_idx
);

    int   start;
    int   idx;
    logic found;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        // A pointer outside 0..5 cannot occur; treat it as "wrap to 0".
        start   = (int'(ptr) >= ARB_N - 1) ? 0 : int'(ptr) + 1;
        for (int k = 0; k < ARB_N; k++) begin
            idx = start + k;
            if (idx >= ARB_N) begin
                idx = idx - ARB_N;
            end
            if (!found && req[idx]) begin
                found   = 1'b1;
                win     = ARB_N'(1) << idx;
                win_idx = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/arbiter_rr6.sv
// arbiter_rr6: six-requester round-robin arbiter with held multi-beat grants.
// Produces a registered one-hot select for a downstream one-hot data mux.
// A grant is held until the final beat is accepted (ready && last), until the
// granted requester drops req, or (with ARB_WATCHDOG_EN defined) until the
// watchdog sees TO_CYCLES consecutive busy cycles without ready.
// On release the next grant is picked in the same cycle, so there is no bubble.
// The released requester ranks lowest in that pick.
// Optional feature macro: ARB_WATCHDOG_EN (watchdog counter and sticky timeout).
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high reset
//   req       in   [5:0] request per source
//   last      in   current beat is the final beat of the transfer
//   ready     in   downstream accepts the current beat
//   sel       out  [5:0] registered one-hot grant
//   valid     out  registered, equals |sel
//   timeout   out  sticky watchdog-release flag (0 without ARB_WATCHDOG_EN)
//   fsm_state out  current FSM state, for observation
module arbiter_rr6
    import arb_pkg::*;
#(
    parameter int TO_CYCLES = 255,
    parameter int CW        = $clog2(TO_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ARB_N-1:0] req,
    input  logic             last,
    input  logic             ready,
    output logic [ARB_N-1:0] sel,
    output logic             valid,
    output logic             timeout,
    output arb_state_e       fsm_state
);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [ARB_N-1:0] sel_q, sel_d;
    logic             valid_q;
    logic [ARB_N-1:0] win;
    logic [PTR_W-1:0] win_idx;
    logic             rel;
    logic             load;
    logic             wd_fire;

    // ptr_q is the current owner while BUSY, so one pick from ptr_q serves
    // both the grant from IDLE and the re-pick on release.
    rr_pick6 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    // sel_q is one-hot on the owner, so this is req[owner] without indexing.
    assign rel = (state_q == BUSY) &&
                 ((ready && last) || ((req & sel_q) == '0) || wd_fire);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    load = 1'b1;
                end
            end
            BUSY: begin
                if (rel) begin
                    if (|win) begin
                        load = 1'b1;
                    end else begin
                        sel_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
        if (load) begin
            sel_d   = win;
            ptr_d   = win_idx;
            state_d = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(ARB_N - 1);
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            valid_q <= |sel_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    logic [CW-1:0] wd_cnt;
    logic          timeout_q;

    // Fires on the stalled edge that would take the count to TO_CYCLES.
    // The grant is therefore visible for exactly TO_CYCLES stalled cycles.
    assign wd_fire = (state_q == BUSY) && !ready &&
                     (wd_cnt == CW'(TO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (load || ready) begin
                wd_cnt <= '0;
            end else if (state_q == BUSY) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    assign sel       = sel_q;
    assign valid     = valid_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_arbiter_rr6.sv
// tb_arbiter_rr6: self-checking bench for arbiter_rr6.
// The reference model tracks the owner as an integer (-1 = nobody).
// Priority is derived by scanning requesters cyclically after the previous
// winner. Build with ARB_WATCHDOG_EN defined to also exercise the watchdog.
module tb_arbiter_rr6;
    import arb_pkg::*;

    localparam int TO = 8;

    logic       clk;
    logic       reset;
    logic [5:0] req;
    logic       last;
    logic       ready;
    logic [5:0] sel;
    logic       valid;
    logic       timeout;
    arb_state_e fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_owner;
    int m_last_win;
    bit m_timeout;
    int m_stall;

    logic [5:0] exp_q[$];

    arbiter_rr6 #(.TO_CYCLES(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .ready     (ready),
        .sel       (sel),
        .valid     (valid),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(logic [5:0] r, int after);
        for (int k = 1; k <= 6; k++) begin
            int i;
            i = (after + k) % 6;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [5:0] exp_sel();
        if (m_owner < 0) return 6'd0;
        return 6'd1 << m_owner;
    endfunction

    task automatic model_step();
        bit wd;
        bit rls;
        int p;
        if (reset) begin
            m_owner = -1; m_last_win = 5; m_timeout = 0; m_stall = 0;
        end else if (m_owner < 0) begin
            p = pick(req, m_last_win);
            if (p >= 0) begin
                m_owner = p; m_last_win = p; m_stall = 0;
            end
        end else begin
            wd = 0;
`ifdef ARB_WATCHDOG_EN
            wd = !ready && (m_stall + 1 == TO);
`endif
            m_stall = ready ? 0 : m_stall + 1;
            rls = (ready && last) || !req[m_owner] || wd;
            if (wd) m_timeout = 1;
            if (rls) begin
                p = pick(req, m_owner);
                if (p >= 0) begin
                    m_owner = p; m_last_win = p; m_stall = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    // driver: one clock, model follows the same sampled inputs
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; last = 1'b0; ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (sel !== 6'd0) begin n_bad++; $display("FAIL reset_sel got=%b exp=000000", sel); end
        n_cmp++;
        if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_cmp++;
        if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    endtask

    task automatic test_alternate();
        logic [5:0] e;
        do_reset();
        req = 6'b001001; ready = 1'b1; last = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            e = (c % 2 == 0) ? 6'b000001 : 6'b001000;
            n_cmp++;
            if (sel !== e || sel !== exp_sel()) begin
                n_bad++; $display("FAIL alternate c=%0d got=%b exp=%b", c, sel, e);
            end
        end
    endtask

    task automatic test_multibeat();
        int held;
        do_reset();
        req = 6'b000100; ready = 1'b1; last = 1'b0;
        tick();
        n_cmp++;
        if (sel !== 6'b000100) begin n_bad++; $display("FAIL mb_grant got=%b exp=000100", sel); end
        held = 0;
        for (int beat = 1; beat <= 4; beat++) begin
            if (sel === 6'b000100) held++;
            if (beat >= 2) req = 6'b100100;
            last = (beat == 4);
            tick();
        end
        n_cmp++;
        if (held !== 4) begin n_bad++; $display("FAIL mb_hold got=%0d exp=4", held); end
        n_cmp++;
        if (sel !== 6'b100000 || sel !== exp_sel()) begin
            n_bad++; $display("FAIL mb_handover got=%b exp=100000", sel);
        end
    endtask

    task automatic test_all_six();
        logic [5:0] e;
        do_reset();
        for (int i = 0; i < 13; i++) exp_q.push_back(6'd1 << (i % 6));
        req = 6'b111111; ready = 1'b1; last = 1'b1;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (sel !== e || valid !== 1'b1) begin
                n_bad++; $display("FAIL all_six got=%b valid=%b exp=%b", sel, valid, e);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 6'b001000; ready = 1'b0; last = 1'b0;
        tick();
        req = 6'b001010;
        tick();
        n_cmp++;
        if (sel !== 6'b001000) begin n_bad++; $display("FAIL drop_hold got=%b exp=001000", sel); end
        req = 6'b000010;
        tick();
        n_cmp++;
        if (sel !== 6'b000010 || valid !== 1'b1) begin
            n_bad++; $display("FAIL drop_handover got=%b valid=%b exp=000010", sel, valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 6'b000010; ready = 1'b1; last = 1'b0;
        tick();
        tick();
        reset = 1'b1; req = 6'b100010;
        tick();
        n_cmp++;
        if (sel !== 6'd0 || valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid got=%b valid=%b exp=000000/0", sel, valid);
        end
        reset = 1'b0; req = 6'b100001;
        tick();
        n_cmp++;
        if (sel !== 6'b000001 || sel !== exp_sel()) begin
            n_bad++; $display("FAIL rst_mid_regrant got=%b exp=000001", sel);
        end
    endtask

    task automatic test_watchdog();
`ifdef ARB_WATCHDOG_EN
        int held;
        do_reset();
        req = 6'b000001; ready = 1'b0; last = 1'b0;
        tick();
        req = 6'b000011;
        held = 0;
        for (int c = 0; c < 12 && sel === 6'b000001; c++) begin
            held++;
            tick();
        end
        n_cmp++;
        if (held !== TO) begin n_bad++; $display("FAIL wd_hold got=%0d exp=%0d", held, TO); end
        n_cmp++;
        if (sel !== 6'b000010 || timeout !== 1'b1) begin
            n_bad++; $display("FAIL wd_release got=%b to=%b exp=000010/1", sel, timeout);
        end
        ready = 1'b1; last = 1'b1;
        tick(); tick();
        n_cmp++;
        if (timeout !== 1'b1) begin n_bad++; $display("FAIL wd_sticky got=%b exp=1", timeout); end
        do_reset();
        n_cmp++;
        if (timeout !== 1'b0) begin n_bad++; $display("FAIL wd_clear got=%b exp=0", timeout); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req   = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) req = '0;
            ready = ($urandom_range(0, 3) != 0);
            last  = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 99) == 0);
            tick();
            n_cmp++;
            if (sel !== exp_sel() || valid !== (exp_sel() != 6'd0) || timeout !== m_timeout) begin
                n_bad++;
                $display("FAIL random c=%0d sel=%b valid=%b to=%b exp=%b/%b/%b",
                         c, sel, valid, timeout, exp_sel(), (exp_sel() != 6'd0), m_timeout);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; last = 1'b0; ready = 1'b0;
        m_owner = -1; m_last_win = 5; m_timeout = 0; m_stall = 0;
        test_reset();
        test_alternate();
        test_multibeat();
        test_all_six();
        test_drop();
        test_reset_mid();
        test_watchdog();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
